// File: rtl/pc_pkg.sv
// Shared constants and types for the program-counter stage.
package pc_pkg;

  localparam int unsigned PC_W = 16;
  localparam logic [PC_W-1:0] DEF_RESET_VECTOR = 16'h0000;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_e;

  typedef enum logic [2:0] {
    SEL_HOLD   = 3'd0,
    SEL_SEQ    = 3'd1,
    SEL_BRANCH = 3'd2,
    SEL_JUMP   = 3'd3,
    SEL_RET    = 3'd4
  } next_sel_e;

endpackage

// File: rtl/ret_addr_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ret_addr_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] ptr;
  logic [CW-1:0] count;

  // Pointer and occupancy; the pointer wraps so overwrite-on-full falls out naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + AW'(1);
      if (count != CW'(DEPTH)) begin
        count <= count + CW'(1);
      end
    end else if (pop && (count != '0)) begin
      ptr   <= ptr - AW'(1);
      count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[ptr + AW'(1)] <= push_data;
    end
  end

  assign top   = mem[ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/pc_next_unit.sv
// PC register and next-PC selection for the single-cycle core.
// Optional return-address stack enabled by defining PC_NEXT_RAS_EN.
module pc_next_unit
  import pc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            halt_i,
  input  logic            branch_taken_i,
  input  logic [PC_W-1:0] extended_address_i,
  input  logic            jump_i,
  input  logic [PC_W-1:0] jump_target_i,
  input  logic            call_i,
  input  logic            ret_i,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] pc_plus1_o,
  output logic            fetch_valid_o,
  output logic            halted_o,
  output logic            ras_underflow_o
);

  if ((RAS_DEPTH < 2) || (RAS_DEPTH > 16) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_ras_depth
    $error("RAS_DEPTH must be a power of two in 2..16");
  end

  pc_state_e       state_q, state_d;
  next_sel_e       sel;
  logic [PC_W-1:0] pc_q, pc_d, pc_plus1;
  logic            fetch_valid_q, halted_q;
  logic            underflow_q, underflow_d;
  logic            push_c, pop_c;

  assign pc_plus1 = pc_q + PC_W'(1);

`ifdef PC_NEXT_RAS_EN
  logic [PC_W-1:0] ras_top;
  logic            ras_empty;
  logic            ras_full_unused;

  ret_addr_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push_c),
    .pop       (pop_c),
    .push_data (pc_plus1),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full_unused)
  );
`endif

  // Next state and next-PC source, highest-priority control input wins.
  always_comb begin
    state_d     = state_q;
    sel         = SEL_HOLD;
    push_c      = 1'b0;
    pop_c       = 1'b0;
    underflow_d = 1'b0;
    case (state_q)
      BOOT: begin
        if (!stall_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!stall_i) begin
          if (halt_i) begin
            state_d = HALTED;
          end else if (jump_i) begin
            sel = SEL_JUMP;
          end else if (ret_i) begin
`ifdef PC_NEXT_RAS_EN
            if (ras_empty) begin
              sel         = SEL_SEQ;
              underflow_d = 1'b1;
            end else begin
              sel   = SEL_RET;
              pop_c = 1'b1;
            end
`else
            sel = SEL_SEQ;
`endif
          end else if (call_i) begin
            sel = SEL_JUMP;
`ifdef PC_NEXT_RAS_EN
            push_c = 1'b1;
`endif
          end else if (branch_taken_i) begin
            sel = SEL_BRANCH;
          end else begin
            sel = SEL_SEQ;
          end
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    case (sel)
      SEL_SEQ:    pc_d = pc_plus1;
      SEL_BRANCH: pc_d = pc_plus1 + extended_address_i;
      SEL_JUMP:   pc_d = jump_target_i;
`ifdef PC_NEXT_RAS_EN
      SEL_RET:    pc_d = ras_top;
`endif
      default:    pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= (state_d == RUN);
      halted_q      <= (state_d == HALTED);
      underflow_q   <= underflow_d;
    end
  end

  assign pc_o            = pc_q;
  assign pc_plus1_o      = pc_plus1;
  assign fetch_valid_o   = fetch_valid_q;
  assign halted_o        = halted_q;
  assign ras_underflow_o = underflow_q;

endmodule
